// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD init sequencer: FSM states, HD44780 command
// bytes, the power-on init ROM and default cycle counts for a 50 MHz clock.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT_ISSUE,
        INIT_WAIT,
        INIT_DELAY,
        READY,
        REQ_ISSUE,
        REQ_WAIT,
        REQ_DELAY
    } lcd_state_t;

    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_HOME     = 8'h02;
    localparam logic [7:0] LCD_HOME_ALT = 8'h03;  // DB0 is don't-care for return-home
    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;

    localparam logic [2:0] INIT_LAST = 3'd6;

    localparam int unsigned DEF_PWR_ON_CYCLES  = 750000;
    localparam int unsigned DEF_FIRST_CYCLES   = 205000;
    localparam int unsigned DEF_SHORT_CYCLES   = 5000;
    localparam int unsigned DEF_LONG_CYCLES    = 82000;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1000000;

    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2, 3'd3: return LCD_FUNC_SET;
            3'd4:                   return LCD_DISP_ON;
            3'd5:                   return LCD_CLEAR;
            3'd6:                   return LCD_ENTRY;
            default:                return 8'h00;
        endcase
    endfunction

    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == LCD_CLEAR || data == LCD_HOME || data == LCD_HOME_ALT);
    endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Free-running 32-bit cycle counter with synchronous clear and a terminal-count
// compare; tc pulses for one cycle because the owner clears on tc.
module lcd_delay_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [31:0] terminal,
    output logic        tc
);

    logic [31:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 32'd1;
        end
    end

    assign tc = enable && (count == terminal);

endmodule

// File: rtl/lcd_init_sequencer.sv
// HD44780 command sequencer: power-on wait, fixed init sequence, then host
// bytes forwarded to the byte-write stage, each followed by its execution delay.
module lcd_init_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned PWR_ON_CYCLES  = DEF_PWR_ON_CYCLES,
    parameter int unsigned FIRST_CYCLES   = DEF_FIRST_CYCLES,
    parameter int unsigned SHORT_CYCLES   = DEF_SHORT_CYCLES,
    parameter int unsigned LONG_CYCLES    = DEF_LONG_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       init_done,
    output logic       busy,
    output logic       err,
    output logic       wr_start,
    output logic       wr_rs,
    output logic [7:0] wr_data,
    input  logic       wr_done
);

    lcd_state_t  state;
    logic [2:0]  init_idx;
    logic        in_wait;
    logic        counting;
    logic        cnt_clear;
    logic        tc;
    logic [31:0] terminal;

    function automatic logic [31:0] init_delay(input logic [2:0] idx);
        if (idx == 3'd0)                  return FIRST_CYCLES;
        if (is_long_cmd(1'b0, init_rom(idx))) return LONG_CYCLES;
        return SHORT_CYCLES;
    endfunction

    // NOTE: every variable written here gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        in_wait  = (state == INIT_WAIT) || (state == REQ_WAIT);
        counting = in_wait || (state == PWR_WAIT) || (state == INIT_DELAY)
                   || (state == REQ_DELAY);
        terminal = '0;
        case (state)
            PWR_WAIT:            terminal = PWR_ON_CYCLES - 1;
            INIT_WAIT, REQ_WAIT: terminal = TIMEOUT_CYCLES - 1;
            INIT_DELAY:          terminal = init_delay(init_idx) - 1;
            REQ_DELAY:           terminal = is_long_cmd(wr_rs, wr_data) ? LONG_CYCLES - 1
                                                                        : SHORT_CYCLES - 1;
            default:             terminal = '0;
        endcase
    end

    // Clearing on every transition keeps each state's count starting at zero.
    assign cnt_clear = !counting || tc || (in_wait && wr_done);

    lcd_delay_counter u_delay (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .enable   (counting),
        .terminal (terminal),
        .tc       (tc)
    );

    assign req_ready = (state == READY);
    assign busy      = !req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= PWR_WAIT;
            init_idx  <= '0;
            init_done <= 1'b0;
            err       <= 1'b0;
            wr_start  <= 1'b0;
            wr_rs     <= 1'b0;
            wr_data   <= 8'h00;
        end else begin
            wr_start <= 1'b0;
            case (state)
                PWR_WAIT: if (tc) begin
                    state    <= INIT_ISSUE;
                    wr_start <= 1'b1;
                    wr_rs    <= 1'b0;
                    wr_data  <= init_rom(init_idx);
                end
                INIT_ISSUE: state <= INIT_WAIT;
                INIT_WAIT: if (wr_done || tc) begin
                    // wr_done wins over a coincident timeout
                    if (!wr_done) err <= 1'b1;
                    state <= INIT_DELAY;
                end
                INIT_DELAY: if (tc) begin
                    if (init_idx == INIT_LAST) begin
                        state     <= READY;
                        init_done <= 1'b1;
                    end else begin
                        init_idx <= init_idx + 3'd1;
                        state    <= INIT_ISSUE;
                        wr_start <= 1'b1;
                        wr_rs    <= 1'b0;
                        wr_data  <= init_rom(init_idx + 3'd1);
                    end
                end
                READY: if (req_valid) begin
                    state    <= REQ_ISSUE;
                    wr_start <= 1'b1;
                    wr_rs    <= req_rs;
                    wr_data  <= req_data;
                end
                REQ_ISSUE: state <= REQ_WAIT;
                REQ_WAIT: if (wr_done || tc) begin
                    if (!wr_done) err <= 1'b1;
                    state <= REQ_DELAY;
                end
                REQ_DELAY: if (tc) state <= READY;
                default: state <= PWR_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Self-checking bench for lcd_init_sequencer with small cycle counts and a
// byte-writer model that answers wr_start with wr_done three cycles later.
module tb_lcd_init_sequencer;

    localparam int PWR = 10, FIRST = 8, SHORT = 4, LONG = 12, TMO = 20;
    localparam int WR_LAT = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       wr_done = 1'b0;
    logic       req_ready, init_done, busy, err, wr_start, wr_rs;
    logic [7:0] wr_data;

    always #5 clk = ~clk;

    lcd_init_sequencer #(
        .PWR_ON_CYCLES (PWR),
        .FIRST_CYCLES  (FIRST),
        .SHORT_CYCLES  (SHORT),
        .LONG_CYCLES   (LONG),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_rs   (req_rs),
        .req_data (req_data),
        .init_done(init_done),
        .busy     (busy),
        .err      (err),
        .wr_start (wr_start),
        .wr_rs    (wr_rs),
        .wr_data  (wr_data),
        .wr_done  (wr_done)
    );

    typedef struct { int cyc; logic rs; logic [7:0] data; } start_t;
    typedef struct { logic rs; logic [7:0] data; int exp_delay; } vec_t;

    start_t     starts[$];
    vec_t       vecs[8];
    logic [7:0] rom_ref[7];
    int         cyc, done_at, n_checks, n_fail, cnt55, stable_err;
    bit         withhold, holding;
    logic [7:0] hold_data;
    logic       hold_rs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int ref_init_delay(input int i);
        if (i == 0) return FIRST;
        if (rom_ref[i] == 8'h01 || rom_ref[i] == 8'h02) return LONG;
        return SHORT;
    endfunction

    function automatic int ref_req_delay(input logic rs, input logic [7:0] d);
        return (!rs && d >= 8'd1 && d <= 8'd3) ? LONG : SHORT;
    endfunction

    // One clock: observe outputs after the edge and play the byte writer.
    task automatic step();
        start_t s;
        @(posedge clk);
        #1;
        cyc++;
        if (wr_start === 1'b1) begin
            s.cyc = cyc; s.rs = wr_rs; s.data = wr_data;
            starts.push_back(s);
            if (wr_rs && wr_data == 8'h55) cnt55++;
            hold_data = wr_data;
            hold_rs   = wr_rs;
            holding   = 1'b1;
            if (!withhold) done_at = cyc + WR_LAT;
        end else if (holding && (wr_data !== hold_data || wr_rs !== hold_rs)) begin
            stable_err++;
        end
        wr_done = (cyc == done_at);
    endtask

    task automatic wait_ready(input string tag, output int rc);
        int k = 0;
        while (req_ready !== 1'b1 && k < 200) begin
            step();
            k++;
        end
        rc = cyc;
        if (req_ready !== 1'b1) begin
            check({tag, "_ready_wait"}, 32'(req_ready), 32'd1);
            rc = -1;
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        wr_done = 1'b0;
        done_at = -100;
        holding = 1'b0;
        step();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_busy",      32'(busy),      32'd1);
        check("rst_err",       32'(err),       32'd0);
        check("rst_wr_start",  32'(wr_start),  32'd0);
        check("rst_wr_rs",     32'(wr_rs),     32'd0);
        check("rst_wr_data",   32'(wr_data),   32'd0);
        step();
        reset = 1'b0;
        cyc   = 1;
        starts.delete();
        cnt55 = 0;
    endtask

    task automatic run_init(input string tag);
        int init_cyc = -1;
        int exp_c = PWR + 1;
        for (int k = 0; k < 400; k++) begin
            step();
            if (init_done === 1'b1) begin
                init_cyc = cyc;
                break;
            end
        end
        check({tag, "_init_done"}, 32'(init_done), 32'd1);
        check({tag, "_n_starts"}, 32'(starts.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            if (i < starts.size()) begin
                check($sformatf("%s_start%0d_cyc", tag, i), 32'(starts[i].cyc), 32'(exp_c));
                check($sformatf("%s_start%0d_data", tag, i), 32'(starts[i].data), 32'(rom_ref[i]));
                check($sformatf("%s_start%0d_rs", tag, i), 32'(starts[i].rs), 32'd0);
            end
            exp_c += WR_LAT + ref_init_delay(i) + 1;
        end
        check({tag, "_done_cyc"}, 32'(init_cyc), 32'(exp_c));
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_no_early_req"}, 32'(cnt55), 32'd0);
    endtask

    task automatic transact(input string tag, input logic rs, input logic [7:0] data,
                            input int n_exp);
        int t, r;
        wait_ready(tag, r);
        if (r < 0) return;
        req_valid = 1'b1; req_rs = rs; req_data = data;
        t = cyc;
        step();
        req_valid = 1'b0;
        check({tag, "_wr_start"}, 32'(wr_start), 32'd1);
        check({tag, "_wr_rs"}, 32'(wr_rs), 32'(rs));
        check({tag, "_wr_data"}, 32'(wr_data), 32'(data));
        wait_ready(tag, r);
        if (r >= 0) check({tag, "_ready_gap"}, 32'(r - t), 32'(1 + WR_LAT + n_exp + 1));
    endtask

    initial begin
        int t, s, r;
        logic       rrs;
        logic [7:0] rd;

        rom_ref = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        vecs[0] = '{1'b1, 8'h41, SHORT};
        vecs[1] = '{1'b0, 8'h01, LONG};
        vecs[2] = '{1'b0, 8'h80, SHORT};
        vecs[3] = '{1'b0, 8'h02, LONG};
        vecs[4] = '{1'b0, 8'h03, LONG};
        vecs[5] = '{1'b0, 8'h04, SHORT};
        vecs[6] = '{1'b1, 8'h01, SHORT};
        vecs[7] = '{1'b0, 8'h00, SHORT};

        // Host request held high through init must stall, then go exactly once.
        req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h55;
        do_reset();
        run_init("init");
        t = cyc;
        step();
        req_valid = 1'b0;
        check("held_wr_start", 32'(wr_start), 32'd1);
        check("held_wr_data", 32'(wr_data), 32'h55);
        wait_ready("held", r);
        if (r >= 0) check("held_ready_gap", 32'(r - t), 32'(1 + WR_LAT + SHORT + 1));
        check("held_once", 32'(cnt55), 32'd1);

        // Stray wr_done while idle must be ignored.
        wait_ready("stray", r);
        wr_done = 1'b1;
        step();
        check("stray_ready", 32'(req_ready), 32'd1);
        check("stray_no_start", 32'(wr_start), 32'd0);

        for (int i = 0; i < 8; i++)
            transact($sformatf("vec%0d", i), vecs[i].rs, vecs[i].data, vecs[i].exp_delay);

        // Withheld wr_done: timeout flags err, delay still applies.
        wait_ready("tmo", r);
        withhold  = 1'b1;
        req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h20;
        step();
        req_valid = 1'b0;
        s = cyc;
        check("tmo_wr_start", 32'(wr_start), 32'd1);
        while (cyc < s + TMO - 1) step();
        check("tmo_err_early", 32'(err), 32'd0);
        step();
        step();
        check("tmo_err_set", 32'(err), 32'd1);
        withhold = 1'b0;
        wait_ready("tmo", r);
        if (r >= 0) check("tmo_ready_gap", 32'(r - s), 32'(TMO + SHORT + 1));
        transact("post_tmo", 1'b0, 8'h80, SHORT);
        check("err_sticky", 32'(err), 32'd1);

        // Reset while the downstream write is outstanding.
        wait_ready("midrst", r);
        req_valid = 1'b1; req_rs = 1'b0; req_data = 8'h01;
        step();
        req_valid = 1'b0;
        step();
        check("midrst_in_wait", 32'(req_ready), 32'd0);
        do_reset();
        run_init("reinit");

        for (int i = 0; i < 25; i++) begin
            rrs = 1'($urandom_range(0, 1));
            rd  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
            for (int g = $urandom_range(0, 3); g > 0; g--) step();
            transact($sformatf("rnd%0d", i), rrs, rd, ref_req_delay(rrs, rd));
        end

        check("wr_bus_stable", 32'(stable_err), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got time %0t expected under 500000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lcd_init_sequencer.md
Name: lcd_init_sequencer

Overview:
Command sequencer that sits directly upstream of the single-byte LCD write stage (HD44780-style, 8-bit bus, RS/E/data). After reset it waits out LCD power-on and issues the mandatory initialization command sequence. It then accepts host command/character bytes over a valid/ready handshake and forwards each one to the byte-write stage via a start/done handshake. Each byte is followed by the controller execution delay that byte requires.

Parameters:
PWR_ON_CYCLES, 750000, power-on wait before first command (15 ms @ 50 MHz)
FIRST_CYCLES, 205000, delay after first function-set (4.1 ms)
SHORT_CYCLES, 5000, delay after ordinary command/data byte (100 us)
LONG_CYCLES, 82000, delay after clear/home commands (1.64 ms)
TIMEOUT_CYCLES, 1000000, max wait for wr_done before flagging error

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  host byte request valid
req_ready  out  1  sequencer can accept a host byte
req_rs  in  1  0 = command, 1 = character data
req_data  in  8  byte to write
init_done  out  1  init sequence complete; stays high until reset
busy  out  1  high in every state except READY
err  out  1  sticky; a write timed out waiting for wr_done
wr_start  out  1  one-cycle pulse starting a byte write downstream
wr_rs  out  1  register select for downstream write
wr_data  out  8  byte for downstream write
wr_done  in  1  one-cycle pulse from downstream: byte written

Behaviour:
- Reset is synchronous, active-high, clock clk. Reset values:
  - req_ready=0, init_done=0, busy=1, err=0
  - wr_start=0, wr_rs=0, wr_data=8'h00
  - state=PWR_WAIT, counter=0, init index=0
- Reset mid-operation aborts any transfer immediately and restarts the full power-on sequence. Downstream shares the same reset.
- States:
  - PWR_WAIT -> INIT_ISSUE after counter reaches PWR_ON_CYCLES-1.
  - INIT_ISSUE: drive wr_rs=0, wr_data=ROM[idx]; pulse wr_start for 1 cycle; -> INIT_WAIT.
  - INIT_WAIT: on wr_done -> INIT_DELAY, counter cleared.
  - INIT_DELAY: counts the delay for ROM[idx], then idx+1 -> INIT_ISSUE. After idx 6 -> READY with init_done=1.
  - READY: req_ready=1, busy=0. On req_valid&&req_ready (cycle T): capture rs/data, -> REQ_ISSUE.
  - REQ_ISSUE: wr_start pulse at T+1; -> REQ_WAIT.
  - REQ_WAIT: on wr_done -> REQ_DELAY.
  - REQ_DELAY: counts the delay, then -> READY.
- Init ROM (idx 0..6): 38,38,38,38,0C,01,06 hex.
- Init delays:
  - idx0: FIRST_CYCLES
  - idx5 (clear): LONG_CYCLES
  - all others: SHORT_CYCLES
- Request delay: LONG_CYCLES if rs=0 and data is 01, 02 or 03 hex; otherwise SHORT_CYCLES.
- Timing: if wr_done arrives at cycle D, the delay state is entered at D+1. With delay N, it exits at D+N, and req_ready=1 again at D+N+1.
- wr_rs/wr_data are held stable from the wr_start cycle until wr_done, and also through the following delay.
- wr_done outside INIT_WAIT/REQ_WAIT is ignored.
- req_ready is combinationally 0 outside READY, so host requests during init or during a transfer simply stall.
- Timeout: in a WAIT state, if the counter reaches TIMEOUT_CYCLES-1 without wr_done:
  - err is set;
  - the state proceeds as if wr_done had arrived (the delay still applies);
  - err clears only on reset.
- Counter is 32-bit unsigned, cleared on every state change; it never wraps in legal operation.
- If wr_done and the timeout coincide, wr_done wins and err is not set.

Decomposition:
- Shared package lcd_pkg holds:
  - state enum;
  - command constants LCD_CLEAR=01, LCD_HOME=02, LCD_FUNC_SET=38, LCD_DISP_ON=0C, LCD_ENTRY=06;
  - init ROM as a constant function;
  - default cycle counts.
- One sub-module: lcd_delay_counter (clear, enable, 32-bit terminal-count compare, tc pulse output), instantiated once.

Test Plan:
All tests use overrides PWR_ON=10, FIRST=8, SHORT=4, LONG=12, TIMEOUT=20. A bench byte-writer model returns wr_done 3 cycles after wr_start.
- Reset release -> first wr_start with wr_data=38 on the 11th cycle. Seven wr_start pulses with data 38,38,38,38,0C,01,06 and the correct gaps (8 after the first, 12 after 01, 4 elsewhere). init_done=1 and req_ready=1 after the last delay.
- After init, req_valid with rs=1, data=41 at cycle T -> wr_start at T+1 with wr_rs=1, wr_data=41. req_ready returns at done+5.
- Command 01 request -> LONG delay: req_ready returns 13 cycles after wr_done. Command 80 -> SHORT delay (5 cycles).
- req_valid held high during init with data 55 -> no wr_start carrying 55 before init_done. Accepted exactly once after init.
- Model withholds wr_done -> err=1 twenty cycles after wr_start; sequence continues; err stays 1 until reset.
- Assert reset during REQ_WAIT -> next cycle wr_start=0, init_done=0, req_ready=0. Full init sequence repeats.
